// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (common with ALU control) and FSM state encoding.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND     = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR      = 4'b0001;
  localparam logic [OP_W-1:0] ALU_NOR     = 4'b0010;
  localparam logic [OP_W-1:0] ALU_ADD     = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SUB     = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SLL     = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SRL     = 4'b0110;
  localparam logic [OP_W-1:0] ALU_DEFAULT = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Request/response bundle between the multicycle control FSM (master) and the ALU (slave).
interface alu_iterative_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [3:0]         ALUOperation;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   ALUResult;
  logic               Zero;

  modport master (
    output start, ALUOperation, A, B, shamt,
    input  busy, done, ALUResult, Zero
  );

  modport slave (
    input  start, ALUOperation, A, B, shamt,
    output busy, done, ALUResult, Zero
  );
endinterface

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter: shift register plus down-counter, runs while the count is nonzero.
module alu_shift_iter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               dir_i,
  input  logic [WIDTH-1:0]   value_i,
  input  logic [SHAMT_W-1:0] amount_i,
  output logic               step_done_c,
  output logic [WIDTH-1:0]   q_c
);

  logic [WIDTH-1:0]   sh_q;
  logic [SHAMT_W-1:0] cnt_q;

  // q_c is the register value after the current step; dir_i=1 shifts right.
  assign q_c         = dir_i ? (sh_q >> 1) : (sh_q << 1);
  assign step_done_c = (cnt_q == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= value_i;
      cnt_q <= amount_i;
    end else if (cnt_q != '0) begin
      sh_q  <= q_c;
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: logic/arith ops in one cycle, SLL/SRL iterated one bit per cycle,
// with a start/busy/done handshake and registered ALUResult/Zero.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  alu_iterative_if.slave bus
);

  alu_state_e       state_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             shift_load;
  logic             shift_dir;
  logic             step_done_c;
  logic [WIDTH-1:0] shift_q_c;
  logic [WIDTH-1:0] unit_result;

  assign accept     = (state_q == IDLE) && bus.start;
  assign shift_load = accept && is_shift_op(bus.ALUOperation) && (bus.shamt != '0);
  assign shift_dir  = (op_q == ALU_SRL);

  // Single-cycle logic unit; also covers shifts by zero, which just pass B.
  always_comb begin
    unit_result = '0;
    case (bus.ALUOperation)
      ALU_AND: unit_result = bus.A & bus.B;
      ALU_OR:  unit_result = bus.A | bus.B;
      ALU_NOR: unit_result = ~(bus.A | bus.B);
      ALU_ADD: unit_result = bus.A + bus.B;
      ALU_SUB: unit_result = bus.A - bus.B;
      ALU_SLL: unit_result = bus.B << bus.shamt;
      ALU_SRL: unit_result = bus.B >> bus.shamt;
      default: unit_result = '0;
    endcase
  end

  alu_shift_iter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk         (clk),
    .reset       (reset),
    .load_i      (shift_load),
    .dir_i       (shift_dir),
    .value_i     (bus.B),
    .amount_i    (bus.shamt),
    .step_done_c (step_done_c),
    .q_c         (shift_q_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.ALUOperation;
            busy_q <= 1'b1;
            if (shift_load) begin
              state_q <= SHIFT;
            end else begin
              result_q <= unit_result;
              zero_q   <= (unit_result == '0);
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        SHIFT: begin
          // Result stays frozen until the final step lands.
          if (step_done_c) begin
            result_q <= shift_q_c;
            zero_q   <= (shift_q_c == '0);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed corner cases plus random ops against a reference model.
module tb_alu_iterative;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_iterative_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  alu_iterative #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
    int unsigned n;
    n = sh;
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return ~(a | b);
      4'd3: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd4: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'd5: return 32'((64'(b) * (64'd1 << n)) % 64'h1_0000_0000);
      4'd6: return b / (32'd1 << n);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [4:0] sh);
    if ((op == 4'd5 || op == 4'd6) && sh != 5'd0) return 1 + int'(sh);
    return 1;
  endfunction

  // Issue one op with a single-cycle start, scramble inputs afterwards, and check the outcome.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] held;
    logic [31:0] exp;
    int want;
    int lat;
    bit held_ok;
    bit busy_ok;
    held    = bus.ALUResult;
    exp     = ref_result(op, a, b, sh);
    want    = ref_latency(op, sh);
    held_ok = 1'b1;
    busy_ok = 1'b1;
    bus.start = 1'b1; bus.ALUOperation = op; bus.A = a; bus.B = b; bus.shamt = sh;
    tick;
    bus.start = 1'b0;
    bus.ALUOperation = 4'($urandom); bus.A = $urandom; bus.B = $urandom; bus.shamt = 5'($urandom);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.ALUResult !== held) held_ok = 1'b0;
      tick;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(want));
    check({tag, " result"}, bus.ALUResult, exp);
    check({tag, " zero"}, {31'd0, bus.Zero}, {31'd0, exp == 32'd0});
    check({tag, " busy@done"}, {31'd0, bus.busy}, 32'd1);
    if (want > 1) begin
      check({tag, " busy during shift"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " result held during shift"}, {31'd0, held_ok}, 32'd1);
    end
    tick;
    check({tag, " busy after"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " done after"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int pulses;
    int lat;
    logic [3:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0] rsh;

    reset = 1'b1;
    bus.start = 1'b0; bus.ALUOperation = 4'd0; bus.A = '0; bus.B = '0; bus.shamt = '0;
    tick;
    tick;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.ALUResult, 32'd0);
    check("reset zero", {31'd0, bus.Zero}, 32'd1);
    reset = 1'b0;
    tick;

    run_op("add wrap", 4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    run_op("sub neg", 4'd4, 32'd5, 32'd7, 5'd9);
    run_op("nor zero", 4'd2, 32'd0, 32'd0, 5'd0);
    run_op("and", 4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3);
    run_op("or", 4'd1, 32'hA000_0001, 32'h0500_0010, 5'd0);
    run_op("sll 31", 4'd5, 32'h1234_5678, 32'h0000_0001, 5'd31);
    run_op("srl 4", 4'd6, 32'd0, 32'h8000_0000, 5'd4);
    run_op("srl 0", 4'd6, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0);
    run_op("sll 0", 4'd5, 32'd0, 32'h8765_4321, 5'd0);
    run_op("unknown op", 4'b1001, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 10));
      ra  = $urandom;
      rb  = $urandom;
      rsh = 5'($urandom);
      run_op("random", rop, ra, rb, rsh);
    end

    // Abandon a long shift with reset; make the prior result nonzero first.
    run_op("pre-reset or", 4'd1, 32'h0000_0001, 32'h0000_0000, 5'd0);
    bus.start = 1'b1; bus.ALUOperation = 4'd5; bus.B = 32'h0000_0003; bus.shamt = 5'd20;
    tick;
    bus.start = 1'b0;
    repeat (4) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midshift reset busy", {31'd0, bus.busy}, 32'd0);
    check("midshift reset done", {31'd0, bus.done}, 32'd0);
    check("midshift reset result", bus.ALUResult, 32'd0);
    check("midshift reset zero", {31'd0, bus.Zero}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      tick;
    end
    check("no activity after reset", 32'(pulses), 32'd0);

    // start held high, operands changed after latching; second op only after DONE.
    bus.start = 1'b1; bus.ALUOperation = 4'd5; bus.A = 32'h1111_1111; bus.B = 32'h0000_00F1; bus.shamt = 5'd3;
    tick;
    bus.A = 32'h2222_2222; bus.B = 32'h0000_0F00;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.done === 1'b1) pulses++;
      tick;
    end
    check("held start done count pre", 32'(pulses), 32'd0);
    check("held start done cycle", {31'd0, bus.done}, 32'd1);
    check("held start result", bus.ALUResult, 32'h0000_0788);
    tick;
    check("held start idle gap busy", {31'd0, bus.busy}, 32'd0);
    check("held start idle gap done", {31'd0, bus.done}, 32'd0);
    tick;
    check("held start second accept", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    check("second op latency", 32'(lat), 32'd4);
    check("second op result", bus.ALUResult, 32'h0000_7800);
    tick;
    check("second op busy after", {31'd0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Execute stage ALU that consumes the 4-bit ALUOperation code from the ALU control unit, together with the register operands and the shift amount.
- AND/OR/NOR/ADD/SUB complete in one cycle. SLL/SRL run as an iterative shifter, one bit per cycle, which saves the barrel-shifter area.
- Start/busy/done handshake toward the multicycle control FSM. Result and Zero are registered and held until the next completion.

Parameters:
- WIDTH, 32, datapath width in bits
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- ALUOperation  in  4  operation code from ALU control
- A  in  WIDTH  operand rs
- B  in  WIDTH  operand rt/immediate; this is also the value that gets shifted
- shamt  in  SHAMT_W  shift amount (instruction field)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse: ALUResult/Zero updated this cycle
- ALUResult  out  WIDTH  registered result
- Zero  out  1  registered (ALUResult == 0)

Behaviour:
- Reset (sync, active-high, highest priority):
  - state=IDLE; busy=0, done=0, ALUResult=0, Zero=1.
  - Counter and shift register cleared.
  - Reset mid-shift abandons the operation; no done pulse.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 NOR; 0011 ADD (A+B); 0100 SUB (A-B).
  - 0101 SLL (B<<shamt); 0110 SRL (B>>shamt, logical).
  - Any other code gives result 0.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. No overflow/carry output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches ALUOperation, A, B, shamt.
  - Non-shift op, or shift with shamt=0: compute, register ALUResult/Zero, go to DONE.
  - Shift with shamt>0: load B into the shift register, cnt=shamt, go to SHIFT.
  - start=0: remain in IDLE; outputs hold.
- SHIFT:
  - Each cycle: shift register shifts 1 bit (left for SLL, right for SRL, zero fill); cnt decrements.
  - When cnt==1 on entry to a cycle, that cycle performs the last shift, writes ALUResult/Zero, and moves to DONE.
- DONE: done=1 for exactly one cycle; then IDLE.
- Latency, with start sampled at edge N:
  - done is high in cycle N+1 for non-shift ops or shamt=0.
  - done is high in cycle N+1+shamt for shifts; max N+32 (shamt=31).
- Handshake:
  - start while busy=1 (SHIFT or DONE) is ignored and not queued.
  - Operand input changes after the latching edge have no effect.
- ALUResult/Zero are stable between done pulses. They are not updated during SHIFT.
- busy=1 throughout SHIFT and DONE, including the done cycle.

Decomposition:
- Shared package alu_pkg:
  - ALUOperation code constants (AND..SRL, DEFAULT=4'b1001), shared with the ALU control unit.
  - State encoding constants IDLE/SHIFT/DONE.
- One natural sub-module: alu_shift_iter.
  - Contents: shift register plus down-counter.
  - Ports: load, dir, value, amount, step_done, q.
  - The top level holds the FSM and the single-cycle logic unit.

Test Plan:
- Reset mid-SHIFT (SLL, shamt=20, reset after 5 cycles) -> next cycle busy=0, done=0, ALUResult=0, Zero=1; no done pulse afterward.
- ADD A=0xFFFFFFFF B=0x00000001, start 1 cycle -> done at N+1, ALUResult=0x00000000, Zero=1, busy back to 0 at N+2.
- SUB A=5 B=7 -> ALUResult=0xFFFFFFFE, Zero=0, done at N+1. NOR A=0 B=0 -> 0xFFFFFFFF.
- SLL B=0x00000001 shamt=31 -> busy high N+1..N+32; done only at N+32; ALUResult=0x80000000. SRL B=0x80000000 shamt=4 -> 0x08000000 at N+5.
- Shift shamt=0 (SRL B=0x1234) -> done at N+1, ALUResult=0x00001234. Unknown op 4'b1001 -> ALUResult=0, Zero=1.
- start held high during SLL shamt=3, with A/B changed mid-op -> result uses latched B, exactly one done pulse. The next op is accepted only in the cycle after DONE.
